// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle used on both sides of the two-master arbiter.
// The master modport drives the request; the slave modport answers it.
interface wb_arbiter_2m_if #(
   parameter int AW = 32,
   parameter int DW = 16
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   dat_r;
   logic            ack;
   logic            err;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on ties, no preemption,
// one idle cycle between grants and a slave no-ack timeout.
module wb_arbiter_2m #(
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       m0_cyc_i,
   input  logic                       m0_stb_i,
   input  logic                       m0_we_i,
   input  logic [WB_ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]   m0_dat_i,
   input  logic [WB_DATA_WIDTH/8-1:0] m0_sel_i,
   output logic [WB_DATA_WIDTH-1:0]   m0_dat_o,
   output logic                       m0_ack_o,
   output logic                       m0_err_o,
   input  logic                       m1_cyc_i,
   input  logic                       m1_stb_i,
   input  logic                       m1_we_i,
   input  logic [WB_ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]   m1_dat_i,
   input  logic [WB_DATA_WIDTH/8-1:0] m1_sel_i,
   output logic [WB_DATA_WIDTH-1:0]   m1_dat_o,
   output logic                       m1_ack_o,
   output logic                       m1_err_o,
   output logic                       s_cyc_o,
   output logic                       s_stb_o,
   output logic                       s_we_o,
   output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
   output logic [WB_DATA_WIDTH-1:0]   s_dat_o,
   output logic [WB_DATA_WIDTH/8-1:0] s_sel_o,
   input  logic [WB_DATA_WIDTH-1:0]   s_dat_i,
   input  logic                       s_ack_i,
   output logic [1:0]                 gnt_o
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       last_gnt_q, last_gnt_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         wait_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         wait_q     <= wait_d;
         err_q      <= err_d;
      end
   end

   // Handover always returns to IDLE, so a tenure ends only when cyc drops.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               if (last_gnt_q) begin
                  state_d    = GNT0;
                  last_gnt_d = 1'b0;
               end else begin
                  state_d    = GNT1;
                  last_gnt_d = 1'b1;
               end
            end else if (m0_cyc_i) begin
               state_d    = GNT0;
               last_gnt_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d    = GNT1;
               last_gnt_d = 1'b1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) state_d = IDLE;
         end
         GNT1: begin
            if (!m1_cyc_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o = {state_q == GNT1, state_q == GNT0};

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      case (state_q)
         GNT0: begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
         end
         GNT1: begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
         end
         default: ;
      endcase
   end

   // An ack on the limit cycle clears the counter before a timeout is seen.
   always_comb begin
      wait_d = wait_q;
      err_d  = '0;
      if (state_q == IDLE || !s_stb_o || s_ack_i) begin
         wait_d = '0;
      end else if (wait_q == WAIT_LAST) begin
         wait_d = '0;
         err_d  = gnt_o;
      end else begin
         wait_d = wait_q + 8'd1;
      end
   end

   assign m0_err_o = err_q[0] & gnt_o[0];
   assign m1_err_o = err_q[1] & gnt_o[1];
   assign m0_ack_o = s_ack_i & gnt_o[0] & ~err_q[0];
   assign m1_ack_o = s_ack_i & gnt_o[1] & ~err_q[1];
   assign m0_dat_o = gnt_o[0] ? s_dat_i : '0;
   assign m1_dat_o = gnt_o[1] ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: directed reset/handover cases
// plus randomized two-master traffic against a slave with random latency.
module tb_wb_arbiter_2m;
   localparam int AW = 32;
   localparam int DW = 16;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } req_t;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] rdata;
      int            at;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m0_bus ();
   wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m1_bus ();
   wb_arbiter_2m_if #(.AW(AW), .DW(DW)) s_bus ();

   logic [1:0]    gnt;
   logic          cyc_d [2];
   logic          we_d  [2];
   logic [AW-1:0] adr_d [2];
   logic [DW-1:0] dat_d [2];
   logic [SW-1:0] sel_d [2];

   logic          man_ack  = 1'b0;
   logic          ack_auto = 1'b0;
   logic          auto     = 1'b0;
   logic [DW-1:0] s_rdata  = '0;

   int tests = 0;
   int fails = 0;
   int cyc_cnt = 0;
   int ack_at = -1;

   req_t req_q0[$], req_q1[$];
   rsp_t rsp_q0[$], rsp_q1[$];

   assign m0_bus.cyc   = cyc_d[0];
   assign m0_bus.stb   = cyc_d[0];
   assign m0_bus.we    = we_d[0];
   assign m0_bus.adr   = adr_d[0];
   assign m0_bus.dat_w = dat_d[0];
   assign m0_bus.sel   = sel_d[0];
   assign m1_bus.cyc   = cyc_d[1];
   assign m1_bus.stb   = cyc_d[1];
   assign m1_bus.we    = we_d[1];
   assign m1_bus.adr   = adr_d[1];
   assign m1_bus.dat_w = dat_d[1];
   assign m1_bus.sel   = sel_d[1];
   assign s_bus.ack    = auto ? ack_auto : man_ack;
   assign s_bus.dat_r  = s_rdata;
   assign s_bus.err    = 1'b0;

   wb_arbiter_2m #(
      .WB_ADDR_WIDTH(AW),
      .WB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .m0_cyc_i(m0_bus.cyc),
      .m0_stb_i(m0_bus.stb),
      .m0_we_i(m0_bus.we),
      .m0_adr_i(m0_bus.adr),
      .m0_dat_i(m0_bus.dat_w),
      .m0_sel_i(m0_bus.sel),
      .m0_dat_o(m0_bus.dat_r),
      .m0_ack_o(m0_bus.ack),
      .m0_err_o(m0_bus.err),
      .m1_cyc_i(m1_bus.cyc),
      .m1_stb_i(m1_bus.stb),
      .m1_we_i(m1_bus.we),
      .m1_adr_i(m1_bus.adr),
      .m1_dat_i(m1_bus.dat_w),
      .m1_sel_i(m1_bus.sel),
      .m1_dat_o(m1_bus.dat_r),
      .m1_ack_o(m1_bus.ack),
      .m1_err_o(m1_bus.err),
      .s_cyc_o(s_bus.cyc),
      .s_stb_o(s_bus.stb),
      .s_we_o(s_bus.we),
      .s_adr_o(s_bus.adr),
      .s_dat_o(s_bus.dat_w),
      .s_sel_o(s_bus.sel),
      .s_dat_i(s_bus.dat_r),
      .s_ack_i(s_bus.ack),
      .gnt_o(gnt)
   );

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic void chk(string name, logic [63:0] act,
                               logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   function automatic logic got_resp(int x);
      if (x == 0) return m0_bus.ack | m0_bus.err;
      return m1_bus.ack | m1_bus.err;
   endfunction

   function automatic void sb_check(int x, logic err, logic [DW-1:0] d);
      rsp_t r;
      tests++;
      if ((x == 0 && rsp_q0.size() == 0) ||
          (x == 1 && rsp_q1.size() == 0)) begin
         fails++;
         $display("FAIL m%0d_unexpected_resp: got ack/err, required none", x);
         return;
      end
      if (x == 0) r = rsp_q0.pop_front();
      else r = rsp_q1.pop_front();
      chk("rsp_kind", 64'(err), 64'(r.is_err));
      chk("rsp_cycle", 64'(cyc_cnt), 64'(r.at));
      if (!r.is_err) chk("rsp_data", 64'(d), 64'(r.rdata));
   endfunction

   // Reference arbiter: owner keeps the bus while its cyc is high; after a
   // release the bus is idle a cycle, and a tie goes to the less recent winner.
   logic [1:0] pgnt = '0;
   logic       pc0 = 1'b0;
   logic       pc1 = 1'b0;
   logic       last_w = 1'b1;

   always @(negedge clk) begin : mon
      logic [1:0]  eg;
      int          k;
      logic [52:0] s_exp;
      if (!rst_n) begin
         pgnt   = '0;
         pc0    = 1'b0;
         pc1    = 1'b0;
         last_w = 1'b1;
      end else begin
         if (pgnt == 2'b00) begin
            if (pc0 && pc1) eg = last_w ? 2'b01 : 2'b10;
            else if (pc0) eg = 2'b01;
            else if (pc1) eg = 2'b10;
            else eg = 2'b00;
         end else if (pgnt == 2'b01) begin
            eg = pc0 ? 2'b01 : 2'b00;
         end else begin
            eg = pc1 ? 2'b10 : 2'b00;
         end
         chk("grant", 64'(gnt), 64'(eg));
         if (pgnt == 2'b00 && eg != 2'b00) last_w = eg[1];
         pgnt = eg;
         pc0  = cyc_d[0];
         pc1  = cyc_d[1];

         k = eg[1] ? 1 : 0;
         s_exp = '0;
         if (eg != 2'b00)
            s_exp = {cyc_d[k], cyc_d[k], we_d[k], adr_d[k], dat_d[k], sel_d[k]};
         chk("mirror", 64'({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr,
                            s_bus.dat_w, s_bus.sel}), 64'(s_exp));
         chk("m0_dat", 64'(m0_bus.dat_r), 64'(eg[0] ? s_rdata : '0));
         chk("m1_dat", 64'(m1_bus.dat_r), 64'(eg[1] ? s_rdata : '0));
         chk("m0_ack_err_excl", 64'(m0_bus.ack & m0_bus.err), 64'(0));
         chk("m1_ack_err_excl", 64'(m1_bus.ack & m1_bus.err), 64'(0));
         if (!eg[0]) chk("m0_resp_ungranted", 64'({m0_bus.ack, m0_bus.err}), 64'(0));
         if (!eg[1]) chk("m1_resp_ungranted", 64'({m1_bus.ack, m1_bus.err}), 64'(0));
         if (eg[0] && !m0_bus.err) chk("m0_ack", 64'(m0_bus.ack), 64'(s_bus.ack));
         if (eg[1] && !m1_bus.err) chk("m1_ack", 64'(m1_bus.ack), 64'(s_bus.ack));
         if (auto) begin
            if (got_resp(0)) sb_check(0, m0_bus.err, m0_bus.dat_r);
            if (got_resp(1)) sb_check(1, m1_bus.err, m1_bus.dat_r);
         end
      end
   end

   // Slave: on each new transfer pick a latency; TO means it never acks.
   initial begin : responder
      bit   busy;
      int   x;
      int   lat;
      req_t q;
      rsp_t r;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!auto || !rst_n) begin
            busy   = 1'b0;
            ack_at = -1;
         end else begin
            if (busy && !s_bus.cyc) busy = 1'b0;
            if (!busy && s_bus.cyc && s_bus.stb) begin
               busy = 1'b1;
               x = gnt[1] ? 1 : 0;
               tests++;
               if ((x == 0 && req_q0.size() == 0) ||
                   (x == 1 && req_q1.size() == 0)) begin
                  fails++;
                  $display("FAIL s_req_m%0d: got transfer, required none", x);
               end else begin
                  if (x == 0) q = req_q0.pop_front();
                  else q = req_q1.pop_front();
                  chk("s_we", 64'(s_bus.we), 64'(q.we));
                  chk("s_adr", 64'(s_bus.adr), 64'(q.adr));
                  chk("s_dat", 64'(s_bus.dat_w), 64'(q.dat));
                  chk("s_sel", 64'(s_bus.sel), 64'(q.sel));
               end
               lat      = $urandom_range(1, TO);
               r.is_err = (lat == TO);
               r.rdata  = DW'($urandom);
               r.at     = cyc_cnt + lat;
               s_rdata  = r.rdata;
               ack_at   = r.is_err ? -1 : cyc_cnt + lat;
               if (x == 0) rsp_q0.push_back(r);
               else rsp_q1.push_back(r);
            end
         end
      end
   end

   initial begin : ack_drv
      forever begin
         @(posedge clk);
         #1;
         ack_auto = (cyc_cnt == ack_at);
      end
   end

   task automatic drive_master(input int x, input int n);
      for (int i = 0; i < n; i++) begin
         req_t r;
         int   w;
         r.we  = 1'($urandom);
         r.adr = AW'($urandom);
         r.dat = DW'($urandom);
         r.sel = SW'($urandom);
         @(posedge clk);
         #1;
         we_d[x]  = r.we;
         adr_d[x] = r.adr;
         dat_d[x] = r.dat;
         sel_d[x] = r.sel;
         cyc_d[x] = 1'b1;
         if (x == 0) req_q0.push_back(r);
         else req_q1.push_back(r);
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!got_resp(x) && w < 64);
         tests++;
         if (!got_resp(x)) begin
            fails++;
            $display("FAIL m%0d_wait: got no ack/err in 64 cycles, required one", x);
         end
         @(posedge clk);
         #1;
         cyc_d[x] = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   initial begin : main
      int acks;
      int w;
      for (int i = 0; i < 2; i++) begin
         cyc_d[i] = 1'b0;
         we_d[i]  = 1'b0;
         adr_d[i] = '0;
         dat_d[i] = '0;
         sel_d[i] = '0;
      end
      cyc_d[0] = 1'b1;
      we_d[0]  = 1'b1;
      adr_d[0] = 32'h0000_0010;
      dat_d[0] = 16'hBEEF;
      sel_d[0] = 2'b11;

      repeat (2) @(posedge clk);
      #2;
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_s_cyc_stb", 64'({s_bus.cyc, s_bus.stb}), 64'(0));
      chk("rst_s_bus", 64'({s_bus.we, s_bus.adr, s_bus.dat_w}), 64'(0));
      chk("rst_m0_resp", 64'({m0_bus.ack, m0_bus.err, m0_bus.dat_r}), 64'(0));

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_grant_before_edge", 64'(gnt), 64'(0));
      @(negedge clk);
      chk("single_gnt", 64'(gnt), 64'(2'b01));
      chk("single_s_adr", 64'(s_bus.adr), 64'(32'h10));
      chk("single_s_dat", 64'(s_bus.dat_w), 64'(16'hBEEF));
      chk("single_s_we", 64'({s_bus.cyc, s_bus.stb, s_bus.we}), 64'(3'b111));
      acks = 0;
      @(posedge clk);
      #1;
      man_ack = 1'b1;
      @(negedge clk);
      acks += int'(m0_bus.ack);
      chk("single_m1_ack", 64'(m1_bus.ack), 64'(0));
      @(posedge clk);
      #1;
      man_ack  = 1'b0;
      cyc_d[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         acks += int'(m0_bus.ack);
      end
      chk("single_m0_ack_once", 64'(acks), 64'(1));

      @(posedge clk);
      #1;
      man_ack = 1'b1;
      @(negedge clk);
      chk("idle_ack_ignored", 64'({m0_bus.ack, m1_bus.ack}), 64'(0));
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      auto    = 1'b1;

      fork
         drive_master(0, 40);
         drive_master(1, 40);
      join
      repeat (8) @(posedge clk);
      chk("rsp_q_drained", 64'(rsp_q0.size() + rsp_q1.size()), 64'(0));
      chk("req_q_drained", 64'(req_q0.size() + req_q1.size()), 64'(0));
      #1;
      auto = 1'b0;

      @(posedge clk);
      #1;
      cyc_d[1] = 1'b1;
      adr_d[1] = 32'hA5A5_0004;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (gnt != 2'b10 && w < 10);
      chk("rst_mid_pre_gnt1", 64'(gnt), 64'(2'b10));
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      man_ack = 1'b1;
      #1;
      chk("rst_mid_gnt", 64'(gnt), 64'(0));
      chk("rst_mid_s_cyc", 64'({s_bus.cyc, s_bus.stb}), 64'(0));
      chk("rst_mid_m1_resp", 64'({m1_bus.ack, m1_bus.err}), 64'(0));
      man_ack  = 1'b0;
      cyc_d[0] = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_no_gnt", 64'(gnt), 64'(0));
      @(negedge clk);
      chk("rst_rel_tie_m0", 64'(gnt), 64'(2'b01));
      @(posedge clk);
      #1;
      cyc_d[0] = 1'b0;
      cyc_d[1] = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 32, SHALL set the width of every address port.
REQ-002 Parameter WB_DATA_WIDTH, default 16, SHALL set the width of every data port; select width SHALL be WB_DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, range 2..255, SHALL set the slave no-ack limit.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
REQ-005 The block SHALL have these ports for each master x in {0,1}:
  mx_cyc_i  in  1  bus cycle request
  mx_stb_i  in  1  strobe
  mx_we_i  in  1  write enable
  mx_adr_i  in  WB_ADDR_WIDTH  address
  mx_dat_i  in  WB_DATA_WIDTH  write data
  mx_sel_i  in  WB_DATA_WIDTH/8  byte select
  mx_dat_o  out  WB_DATA_WIDTH  read data
  mx_ack_o  out  1  acknowledge
  mx_err_o  out  1  timeout error
REQ-006 The block SHALL have these shared slave-side ports:
  s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
  s_adr_o  out  WB_ADDR_WIDTH
  s_dat_o  out  WB_DATA_WIDTH
  s_sel_o  out  WB_DATA_WIDTH/8
  s_dat_i  in  WB_DATA_WIDTH  read data
  s_ack_i  in  1  slave acknowledge
  gnt_o  out  2  one-hot grant, bit x = master x
REQ-007 The block SHALL have no other ports.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1. gnt_o SHALL be 00, 01 and 10 in those states respectively.
REQ-009 In IDLE with only mx_cyc_i high, the next state SHALL be GNTx.
REQ-010 In IDLE with both cyc inputs high, the next state SHALL grant the master that is not in register last_gnt (round-robin).
REQ-011 last_gnt SHALL be updated to x on every IDLE->GNTx transition.
REQ-012 In GNTx with mx_cyc_i low, the next state SHALL be IDLE; otherwise the state SHALL stay GNTx. Masters SHALL NOT be preempted.
REQ-013 Every handover SHALL pass through IDLE, giving a minimum of one idle cycle between grants. Arbitration latency from cyc assertion in IDLE to grant SHALL be one cycle.
REQ-014 In GNTx, all s_* outputs SHALL combinationally mirror master x's inputs.
REQ-015 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL be 0.
REQ-016 mx_ack_o SHALL be s_ack_i AND (state==GNTx); the non-granted master's ack and err SHALL be 0.
REQ-017 mx_dat_o SHALL be s_dat_i for the granted master and 0 otherwise.
REQ-018 An 8-bit wait counter SHALL increment each cycle that s_stb_o=1 and s_ack_i=0. It SHALL clear on s_ack_i=1, on s_stb_o=0, and in IDLE.
REQ-019 When the counter equals TIMEOUT_CYCLES-1 and s_ack_i=0, the block SHALL pulse mx_err_o (registered) for exactly one cycle on the next cycle, and the counter SHALL clear.
REQ-020 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, ack SHALL win and no err SHALL be raised.
REQ-021 ack and err SHALL never be high in the same cycle for the same master.
REQ-022 If s_ack_i is high while in IDLE, the block SHALL ignore it.

Reset
REQ-023 While rst_n=0, the block SHALL immediately (asynchronously) force: state IDLE, last_gnt=1 (so master 0 wins the first tie), counter 0, err 0, gnt_o=00, and all s_* and m* outputs 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no ack or err.
REQ-025 The first grant after rst_n deasserts SHALL occur no earlier than the first clk edge after deassertion.

Verification
REQ-026 Single master: m0 asserts cyc/stb, adr=0x0000_0010, we=1, dat=0xBEEF; slave acks in cycle 3. Required: gnt_o=01 one cycle later, slave sees the same values, m0_ack pulses once, m1_ack=0.
REQ-027 Tie after reset: both cyc rise in the same cycle. Required: GNT0 first; after m0 drops cyc, IDLE for one cycle, then GNT1.
REQ-028 Fairness: both masters request continuously, each performing one transfer per tenure. Required: grants alternate 01,00,10,00,01.
REQ-029 Timeout with TIMEOUT_CYCLES=4: slave never acks. Required: exactly one err pulse to the granted master, 4 cycles after stb; no ack.
REQ-030 Ack at boundary: ack arrives exactly when the counter reaches 3 (TIMEOUT_CYCLES=4). Required: ack is delivered and no err is raised.
REQ-031 Reset during GNT1 with stb high. Required: gnt_o=00 and s_cyc_o=0 immediately; after release, a tie is granted to m0.
